// File: rtl/display_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : display_irq_ctrl                                                 |
// | Brief   : Pixel-clock display interrupt controller. Decodes vblank and     |
// |           NUM_LINE_IRQ programmable raster-line events from (sx, sy),      |
// |           keeps per-source pending bits with per-source acknowledge and    |
// |           drives one registered level IRQ = |(pending & enable).           |
// | Option  : define IRQ_OVERRUN_CNT_EN to add o_overrun_cnt, a saturating     |
// |           count of events that landed on an already-pending, un-acked bit.|
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module display_irq_ctrl #(
  parameter int CORDW        = 16,
  parameter int NUM_LINE_IRQ = 4,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int FRAME_CNT_W  = 8
) (
  input  logic                              i_clk,
  input  logic                              rst,
  input  logic [CORDW-1:0]                  sx,
  input  logic [CORDW-1:0]                  sy,
  input  logic                              i_ack_valid,
  input  logic [NUM_LINE_IRQ:0]             i_ack_mask,
  input  logic                              i_cfg_we,
  input  logic [$clog2(NUM_LINE_IRQ+1)-1:0] i_cfg_sel,
  input  logic                              i_cfg_en,
  input  logic [CORDW-1:0]                  i_cfg_line,
  output logic                              o_irq,
  output logic [NUM_LINE_IRQ:0]             o_pending,
`ifdef IRQ_OVERRUN_CNT_EN
  output logic [7:0]                        o_overrun_cnt,
`endif
  output logic [FRAME_CNT_W-1:0]            o_frame_cnt
);

  localparam int               NSRC     = NUM_LINE_IRQ + 1;
  localparam int               SELW     = $clog2(NSRC);
  localparam logic [CORDW-1:0] c_H_ACT  = CORDW'(H_ACTIVE);
  localparam logic [CORDW-1:0] c_V_ACT  = CORDW'(V_ACTIVE);

  logic [NSRC-1:0]        r_pend;
  logic [NSRC-1:0]        r_en;
  logic                   r_irq;
  logic [FRAME_CNT_W-1:0] r_frame;
  logic [CORDW-1:0]       r_line [NUM_LINE_IRQ];

  logic [NSRC-1:0]        w_ev;
  logic [NSRC-1:0]        w_ack;
  logic [NSRC-1:0]        w_pend_nxt;
  logic [NSRC-1:0]        w_en_nxt;
  logic                   w_frame_start;

  assign w_frame_start = (sx == '0) && (sy == '0);
  assign w_ev[0]       = (sx == '0) && (sy == c_V_ACT);

  // Line events fire at the end of the active part of the compared line;
  // compare values outside the active area are kept silent explicitly since
  // sy keeps counting through vertical blanking.
  generate
    for (genvar k = 0; k < NUM_LINE_IRQ; k++) begin : g_line_ev
      assign w_ev[k+1] = (sx == c_H_ACT) && (sy == r_line[k]) && (r_line[k] < c_V_ACT);
    end
  endgenerate

  // Set beats clear so an event coinciding with its own ack is never lost.
  assign w_ack      = i_ack_valid ? i_ack_mask : '0;
  assign w_pend_nxt = (r_pend & ~w_ack) | w_ev;

  // Enable written this cycle already gates the IRQ computed this cycle.
  always_comb begin
    w_en_nxt = r_en;
    if (i_cfg_we) begin
      for (int s = 0; s < NSRC; s++) begin
        if (i_cfg_sel == SELW'(s)) w_en_nxt[s] = i_cfg_en;
      end
    end
  end

  // Pending, enable, IRQ and frame counter state.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_pend  <= NSRC'(1);
      r_en    <= NSRC'(1);
      r_irq   <= 1'b1;
      r_frame <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_en   <= w_en_nxt;
      r_irq  <= |(w_pend_nxt & w_en_nxt);
      if (w_frame_start) r_frame <= r_frame + FRAME_CNT_W'(1);
    end
  end

  // Line compare registers; sel 0 (vblank) and out-of-range sel never match.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_LINE_IRQ; k++) r_line[k] <= '0;
    end else if (i_cfg_we) begin
      for (int k = 0; k < NUM_LINE_IRQ; k++) begin
        if (i_cfg_sel == SELW'(k + 1)) r_line[k] <= i_cfg_line;
      end
    end
  end

  assign o_irq       = r_irq;
  assign o_pending   = r_pend;
  assign o_frame_cnt = r_frame;

`ifdef IRQ_OVERRUN_CNT_EN
  logic [7:0]      r_ovr;
  logic [NSRC-1:0] w_hits;
  logic [8:0]      w_hit_cnt;
  logic [8:0]      w_ovr_sum;

  assign w_hits = w_ev & r_pend & ~w_ack;

  // Several sources may overrun in the same cycle, so add the hit count.
  always_comb begin
    w_hit_cnt = '0;
    for (int s = 0; s < NSRC; s++) w_hit_cnt = w_hit_cnt + 9'(w_hits[s]);
    w_ovr_sum = {1'b0, r_ovr} + w_hit_cnt;
  end

  // Saturating overrun counter, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (rst) begin
      r_ovr <= '0;
    end else begin
      r_ovr <= (w_ovr_sum > 9'd255) ? 8'hFF : w_ovr_sum[7:0];
    end
  end

  assign o_overrun_cnt = r_ovr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_display_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_display_irq_ctrl                                              |
// | Brief   : Directed bench for display_irq_ctrl with a per-source model      |
// |           checked every cycle plus literal expectations.                   |
// | Option  : IRQ_OVERRUN_CNT_EN enables the overrun counter checks.           |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_display_irq_ctrl;

  localparam int NL = 4;
  localparam int NS = NL + 1;
  localparam int HA = 640;
  localparam int VA = 480;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sx, sy;
  logic        ack_valid;
  logic [4:0]  ack_mask;
  logic        cfg_we;
  logic [2:0]  cfg_sel;
  logic        cfg_en;
  logic [15:0] cfg_line;
  logic        irq;
  logic [4:0]  pending;
  logic [7:0]  frame_cnt;
`ifdef IRQ_OVERRUN_CNT_EN
  logic [7:0]  overrun_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: one entry per source.
  bit m_pend [NS];
  bit m_en   [NS];
  int m_line [NL];
  int m_frame;
  int m_ovr;
  bit m_irq;

  display_irq_ctrl dut (
    .i_clk       (clk),
    .rst         (rst),
    .sx          (sx),
    .sy          (sy),
    .i_ack_valid (ack_valid),
    .i_ack_mask  (ack_mask),
    .i_cfg_we    (cfg_we),
    .i_cfg_sel   (cfg_sel),
    .i_cfg_en    (cfg_en),
    .i_cfg_line  (cfg_line),
    .o_irq       (irq),
    .o_pending   (pending),
`ifdef IRQ_OVERRUN_CNT_EN
    .o_overrun_cnt (overrun_cnt),
`endif
    .o_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pend_vec();
    int v = 0;
    for (int s = 0; s < NS; s++) if (m_pend[s]) v |= (1 << s);
    return v;
  endfunction

  // One clock: predict from the inputs, step, then compare every output.
  task automatic tick();
    bit np [NS];
    bit ne [NS];
    int nl [NL];
    int nf, no;
    bit ni, ev, acked;
    if (rst) begin
      for (int s = 0; s < NS; s++) begin np[s] = (s == 0); ne[s] = (s == 0); end
      for (int k = 0; k < NL; k++) nl[k] = 0;
      nf = 0; no = 0; ni = 1;
    end else begin
      ne = m_en; nl = m_line; nf = m_frame; no = m_ovr;
      for (int s = 0; s < NS; s++) begin
        if (s == 0) ev = (sx == 0) && (sy == VA);
        else        ev = (sx == HA) && (int'(sy) == m_line[s-1]) && (m_line[s-1] < VA);
        acked = ack_valid && ack_mask[s];
        if (ev) begin
          if (m_pend[s] && !acked && no < 255) no++;
          np[s] = 1;
        end else begin
          np[s] = m_pend[s] && !acked;
        end
      end
      if (sx == 0 && sy == 0) nf = (nf + 1) % 256;
      if (cfg_we && cfg_sel <= NL) begin
        ne[cfg_sel] = cfg_en;
        if (cfg_sel > 0) nl[cfg_sel-1] = cfg_line;
      end
      ni = 0;
      for (int s = 0; s < NS; s++) ni |= np[s] && ne[s];
    end
    @(posedge clk);
    #1;
    m_pend = np; m_en = ne; m_line = nl; m_frame = nf; m_ovr = no; m_irq = ni;
    chk("irq", int'(irq), int'(m_irq));
    chk("pending", int'(pending), pend_vec());
    chk("frame_cnt", int'(frame_cnt), m_frame);
`ifdef IRQ_OVERRUN_CNT_EN
    chk("overrun_cnt", int'(overrun_cnt), m_ovr);
`endif
    ack_valid = 0;
    cfg_we    = 0;
  endtask

  // Visit one position for a cycle, then park where nothing fires.
  task automatic at(input int x, input int y);
    sx = 16'(x); sy = 16'(y);
    tick();
    sx = 16'd700; sy = 16'd600;
  endtask

  task automatic ack(input logic [4:0] m);
    ack_valid = 1; ack_mask = m;
    tick();
  endtask

  task automatic cfg(input int sel, input int line, input bit en);
    cfg_we = 1; cfg_sel = 3'(sel); cfg_line = 16'(line); cfg_en = en;
    tick();
  endtask

  // Sparse frame: only the coordinates that matter to any source.
  task automatic frame();
    int ys [8] = '{0, 1, 99, 100, 101, 240, 479, 600};
    at(0, 0);
    for (int i = 0; i < 8; i++) at(HA, ys[i]);
    at(639, 100);
    at(0, VA);
    at(HA, VA);
    at(0, 524);
  endtask

  initial begin
    rst = 1; sx = 16'd700; sy = 16'd600;
    ack_valid = 0; ack_mask = '0; cfg_we = 0; cfg_sel = '0; cfg_en = 0; cfg_line = '0;

    // 1: reset state, then ack vblank
    tick();
    rst = 0;
    chk("lit_rst_pending", int'(pending), 1);
    chk("lit_rst_irq", int'(irq), 1);
    chk("lit_rst_frame", int'(frame_cnt), 0);
    tick();
    chk("lit_irq_after_rst", int'(irq), 1);
    ack(5'b00001);
    chk("lit_ack_pending", int'(pending), 0);
    chk("lit_ack_irq", int'(irq), 0);

    // 2: default frame sweep
    at(0, 0);
    chk("lit_frame_cnt1", int'(frame_cnt), 1);
    at(639, VA);
    chk("lit_no_vblank_early", int'(pending[0]), 0);
    at(0, VA);
    chk("lit_vblank_pending", int'(pending[0]), 1);
    chk("lit_vblank_irq", int'(irq), 1);
    for (int y = 0; y < 525; y++) begin
      at(0, y);
      at(HA, y);
    end
    chk("lit_frame_cnt2", int'(frame_cnt), 2);

    // 3: line 100 on source 2, ack colliding with event
    ack(5'b11111);
    cfg(2, 100, 1);
    cfg(7, 5, 1);           // out-of-range select: ignored
    cfg(3, 600, 1);         // beyond active area: never fires
    at(HA, 99);
    chk("lit_line_early", int'(pending[2]), 0);
    at(HA, 100);
    chk("lit_line_pending", int'(pending[2]), 1);
    chk("lit_line_irq", int'(irq), 1);
    ack_valid = 1; ack_mask = 5'b00100;
    at(HA, 100);
    chk("lit_set_wins", int'(pending[2]), 1);
    at(HA, 600);
    chk("lit_silent_line", int'(pending[3]), 0);
    ack(5'b00100);
    chk("lit_line_cleared", int'(pending), 0);
    frame();

    // 4: two channels same line, only one enabled
    ack(5'b11111);
    cfg(1, 100, 0);
    at(HA, 100);
    chk("lit_both_pending", int'(pending[2:1]), 3);
    chk("lit_both_irq", int'(irq), 1);
    ack(5'b00100);
    chk("lit_disabled_irq", int'(irq), 0);
    chk("lit_disabled_keeps", int'(pending[1]), 1);
    cfg(1, 100, 1);
    chk("lit_reenable_irq", int'(irq), 1);
    cfg(1, 100, 0);
    chk("lit_disable_drop", int'(irq), 0);
    cfg(1, 100, 1);
    at(HA, 100);
    ack(5'b00100);
    chk("lit_other_holds", int'(irq), 1);
    frame();

`ifdef IRQ_OVERRUN_CNT_EN
    // 5: overrun saturation
    ack(5'b11111);
    for (int f = 0; f < 300; f++) frame();
    chk("lit_ovr_sat", int'(overrun_cnt), 255);
    rst = 1;
    tick();
    rst = 0;
    chk("lit_ovr_rst", int'(overrun_cnt), 0);
`endif

    // 6: reset mid-frame with activity in the reset cycle, then wrap
    frame();
    at(0, VA);
    sx = 16'd0; sy = 16'd0; rst = 1; ack_valid = 1; ack_mask = 5'b11111;
    cfg_we = 1; cfg_sel = 3'd2; cfg_line = 16'd240; cfg_en = 0;
    tick();
    rst = 0; sx = 16'd700; sy = 16'd240;
    chk("lit_midrst_pending", int'(pending), 1);
    chk("lit_midrst_frame", int'(frame_cnt), 0);
    chk("lit_midrst_irq", int'(irq), 1);
    for (int f = 0; f < 256; f++) frame();
    chk("lit_frame_wrap", int'(frame_cnt), 0);
    frame();
    chk("lit_frame_after_wrap", int'(frame_cnt), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
